sipo_deser: RTL and testbench

//   Serial-in parallel-out deserializer. Sits directly downstream of the PISO

---
 rtl/sipo_deser_pkg.sv | 25 ++
 rtl/sipo_out_buf.sv | 67 ++++++
 rtl/sipo_deser.sv | 90 +++++++++
 tb/tb_sipo_deser.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/sipo_deser_pkg.sv
//------------------------------------------------------------------------------
// sipo_deser_pkg
// Shared types and helpers for the SIPO deserializer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sipo_deser_pkg;

  // Output-buffer occupancy.
  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  // Bit-counter width for a given word width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sipo_out_buf.sv
//------------------------------------------------------------------------------
// sipo_out_buf
// One-entry valid/ready holding register with sticky drop flag.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_out_buf
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  input  logic             dout_ready,
  input  logic             overflow_clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             overflow
);

  buf_state_t       r_state;
  logic [WIDTH-1:0] r_dout;
  logic             r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= BUF_EMPTY;
      r_dout     <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        BUF_EMPTY: begin
          if (word_valid) begin
            r_dout  <= word_in;
            r_state <= BUF_FULL;
          end
          if (overflow_clr) r_overflow <= 1'b0;
        end
        BUF_FULL: begin
          if (word_valid) begin
            // A consumer taking the old word this edge frees the slot, so no bubble.
            if (dout_ready) begin
              r_dout <= word_in;
              if (overflow_clr) r_overflow <= 1'b0;
            end else begin
              r_overflow <= 1'b1;
            end
          end else begin
            if (dout_ready) r_state <= BUF_EMPTY;
            if (overflow_clr) r_overflow <= 1'b0;
          end
        end
        default: r_state <= BUF_EMPTY;
      endcase
    end
  end

  assign dout       = r_dout;
  assign dout_valid = (r_state == BUF_FULL);
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: rtl/sipo_deser.sv
//------------------------------------------------------------------------------
// sipo_deser
// Serial-in parallel-out deserializer with resync and buffered output.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sipo_deser
  import sipo_deser_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overflow,
  input  logic             overflow_clr,
  output logic             busy
);

  localparam int             CNT_W  = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_complete;

  // A resync throws away the partial word before the new bit enters.
  assign w_base = frame_start ? '0 : r_shift;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift_nxt = (w_base << 1) | WIDTH'(sin);
    end else begin : g_lsb_first
      assign w_shift_nxt = (w_base >> 1) | (WIDTH'(sin) << (WIDTH - 1));
    end
  endgenerate

  assign w_complete = sin_valid && !frame_start && (r_cnt == c_last);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (frame_start)     w_cnt_nxt = sin_valid ? CNT_W'(1) : '0;
    else if (w_complete) w_cnt_nxt = '0;
    else if (sin_valid)  w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      if (sin_valid)        r_shift <= w_shift_nxt;
      else if (frame_start) r_shift <= '0;
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign busy = r_busy;

  sipo_out_buf #(
    .WIDTH(WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .word_in     (w_shift_nxt),
    .word_valid  (w_complete),
    .dout_ready  (dout_ready),
    .overflow_clr(overflow_clr),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .overflow    (overflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_sipo_deser.sv
//------------------------------------------------------------------------------
// tb_sipo_deser
// Self-checking bench: LSB-first and MSB-first instances share one stimulus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sipo_deser;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sin = 1'b0, sin_valid = 1'b0, frame_start = 1'b0;
  logic dout_ready = 1'b0, overflow_clr = 1'b0;

  logic [WIDTH-1:0] dout_l, dout_m;
  logic dv_l, dv_m, ovf_l, ovf_m, busy_l, busy_m;

  int checks = 0;
  int errors = 0;

  // Reference model: received bits since last word boundary, plus buffer contents.
  bit               m_bits[$];
  logic [WIDTH-1:0] m_dout_l, m_dout_m;
  logic             m_valid, m_ovf;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .dout(dout_l), .dout_valid(dv_l), .dout_ready(dout_ready),
    .overflow(ovf_l), .overflow_clr(overflow_clr), .busy(busy_l));

  sipo_deser #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .frame_start(frame_start),
    .dout(dout_m), .dout_valid(dv_m), .dout_ready(dout_ready),
    .overflow(ovf_m), .overflow_clr(overflow_clr), .busy(busy_m));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":dout_lsb"}, 32'(dout_l), 32'(m_dout_l));
    chk({tag, ":dout_msb"}, 32'(dout_m), 32'(m_dout_m));
    chk({tag, ":valid_lsb"}, 32'(dv_l), 32'(m_valid));
    chk({tag, ":valid_msb"}, 32'(dv_m), 32'(m_valid));
    chk({tag, ":ovf_lsb"}, 32'(ovf_l), 32'(m_ovf));
    chk({tag, ":ovf_msb"}, 32'(ovf_m), 32'(m_ovf));
    chk({tag, ":busy_lsb"}, 32'(busy_l), 32'(m_bits.size() != 0));
    chk({tag, ":busy_msb"}, 32'(busy_m), 32'(m_bits.size() != 0));
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dout_l = '0;
    m_dout_m = '0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
  endtask

  // Applies the behavioural rules for one clock edge using the driven inputs.
  task automatic model_edge();
    bit               done;
    bit               drop;
    logic [WIDTH-1:0] wl, wm;
    done = 0;
    drop = 0;
    wl   = '0;
    wm   = '0;
    if (frame_start) m_bits.delete();
    if (sin_valid) m_bits.push_back(sin);
    if (m_bits.size() == WIDTH) begin
      done = 1;
      for (int i = 0; i < WIDTH; i++) begin
        wl[i]           = m_bits[i];
        wm[WIDTH-1-i]   = m_bits[i];
      end
      m_bits.delete();
    end
    if (done) begin
      if (!m_valid || dout_ready) begin
        m_valid  = 1'b1;
        m_dout_l = wl;
        m_dout_m = wm;
      end else begin
        drop  = 1;
        m_ovf = 1'b1;
      end
    end else if (m_valid && dout_ready) begin
      m_valid = 1'b0;
    end
    if (!drop && overflow_clr) m_ovf = 1'b0;
  endtask

  task automatic step(input logic s, input logic v, input logic fs, input logic rdy,
                      input logic clr, input string tag);
    sin          = s;
    sin_valid    = v;
    frame_start  = fs;
    dout_ready   = rdy;
    overflow_clr = clr;
    @(posedge clk);
    if (!rst) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input logic rdy, input string tag);
    for (int i = 0; i < WIDTH; i++) step(w[i], 1'b1, 1'b0, rdy, 1'b0, tag);
  endtask

  // Asynchronous reset pulse; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all({tag, ":async"});
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all({tag, ":held"});
  endtask

  initial begin
    logic [WIDTH-1:0] rw;
    model_reset();
    @(posedge clk);
    #1;
    async_reset("reset");

    // Stream 1,1,0,1: LSB instance sees 4'b1011, MSB instance 4'b1101.
    send_word(4'b1011, 1'b1, "t1");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t1_drain");

    // Stream 1,0,1,1 gives 4'b1011 on the MSB-first instance.
    send_word(4'b1101, 1'b1, "t2");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t2_drain");

    // Backpressure: second word dropped, then clr vs. simultaneous drop.
    send_word(4'hA, 1'b0, "t3a");
    send_word(4'h5, 1'b0, "t3b");
    send_word(4'h5, 1'b0, "t3c");
    for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t3d");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "t3_clr_vs_drop");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_clr");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t3_drain");

    // Back-to-back words with ready on the completion edge.
    send_word(4'h3, 1'b1, "t4a");
    send_word(4'hC, 1'b1, "t4b");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "t4_drain");

    // Resync after two stray bits, with and without a bit on the resync edge.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5_stray");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5_stray");
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "t5_fs");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t5_gap");
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "t5");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t5_last");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t5_more");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "t5_fs_novalid");

    // Reset mid-word and while the buffer is full.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_part");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "t6_part");
    async_reset("t6_midword");
    send_word(4'h9, 1'b0, "t6_full");
    async_reset("t6_midfull");
    send_word(4'h6, 1'b0, "t6_clean");

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      rw = WIDTH'($urandom);
      step(rw[0], ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
           rw[1], ($urandom_range(0, 15) == 0), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
